// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI4 read/write channel bundle between interconnect and SRAM slave.
interface axi_sram_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [3:0]        WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 single/INCR-burst slave onto a single-port word SRAM.
// One transaction in flight; a write wins a simultaneous AW/AR.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    axi_sram_slave_if.slave    bus,
    output logic               sram_ceb,
    output logic [3:0]         sram_web,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [DATA_W-1:0]  sram_di,
    input  logic [DATA_W-1:0]  sram_do
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_FETCH = 3'd1;
    localparam logic [2:0] RD_DATA  = 3'd2;
    localparam logic [2:0] WR_DATA  = 3'd3;
    localparam logic [2:0] WR_RESP  = 3'd4;

    logic [2:0]         state;
    logic [ID_W-1:0]    id;
    logic [SRAM_AW-1:0] idx;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   beat;
    logic               incr;
    logic               first;
    logic               full;
    logic [1:0]         bresp;
    logic [DATA_W-1:0]  hold;
    logic               last;
    logic               r_hs;
    logic               w_hs;
    logic               rd_en;
    logic               wr_en;
    logic               unused;

    assign last  = beat == len;
    assign r_hs  = bus.RVALID & bus.RREADY;
    assign w_hs  = bus.WVALID & bus.WREADY;
    // Prefetch the next beat on each accepted read so RREADY held high gives one beat per cycle.
    assign rd_en = incr & ((state == RD_FETCH) | ((state == RD_DATA) & r_hs & ~last));
    assign wr_en = incr & ~full & (state == WR_DATA) & bus.WVALID & (|bus.WSTRB);

    assign bus.AWREADY = ~rst & (state == IDLE);
    assign bus.ARREADY = ~rst & (state == IDLE) & ~bus.AWVALID;
    assign bus.RVALID  = state == RD_DATA;
    assign bus.RID     = id;
    assign bus.RLAST   = bus.RVALID & last;
    assign bus.RRESP   = (bus.RVALID & ~incr) ? 2'b10 : 2'b00;
    assign bus.RDATA   = (bus.RVALID & incr) ? (first ? sram_do : hold) : '0;
    assign bus.WREADY  = state == WR_DATA;
    assign bus.BVALID  = state == WR_RESP;
    assign bus.BID     = id;
    assign bus.BRESP   = bus.BVALID ? bresp : 2'b00;

    assign sram_ceb = ~(rd_en | wr_en);
    assign sram_web = wr_en ? ~bus.WSTRB : 4'hF;
    assign sram_a   = (state == RD_DATA) ? idx + 1'b1 : idx;
    assign sram_di  = wr_en ? bus.WDATA : '0;

    assign unused = &{1'b0, bus.ARSIZE, bus.AWSIZE, bus.ARADDR[ADDR_W-1:SRAM_AW+2], bus.ARADDR[1:0],
                      bus.AWADDR[ADDR_W-1:SRAM_AW+2], bus.AWADDR[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            id    <= '0;
            idx   <= '0;
            len   <= '0;
            beat  <= '0;
            incr  <= 1'b0;
            first <= 1'b0;
            full  <= 1'b0;
            bresp <= 2'b00;
            hold  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.AWVALID) begin
                        state <= WR_DATA;
                        id    <= bus.AWID;
                        idx   <= bus.AWADDR[SRAM_AW+1:2];
                        len   <= bus.AWLEN;
                        incr  <= bus.AWBURST == 2'b01;
                        beat  <= '0;
                        full  <= 1'b0;
                    end else if (bus.ARVALID) begin
                        state <= RD_FETCH;
                        id    <= bus.ARID;
                        idx   <= bus.ARADDR[SRAM_AW+1:2];
                        len   <= bus.ARLEN;
                        incr  <= bus.ARBURST == 2'b01;
                        beat  <= '0;
                    end
                end
                RD_FETCH: begin
                    state <= RD_DATA;
                    first <= 1'b1;
                end
                RD_DATA: begin
                    // SRAM output is only valid in the first cycle of a beat; keep a copy for stalls.
                    if (first) hold <= sram_do;
                    first <= r_hs;
                    if (r_hs) begin
                        state <= last ? IDLE : RD_DATA;
                        idx   <= idx + 1'b1;
                        beat  <= beat + 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_hs & ~full) begin
                        idx  <= idx + 1'b1;
                        beat <= beat + 1'b1;
                        full <= last;
                    end
                    if (w_hs & bus.WLAST) begin
                        state <= WR_RESP;
                        bresp <= (incr & ~full & last) ? 2'b00 : 2'b10;
                    end
                end
                WR_RESP: if (bus.BREADY) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI4 slave responder that serves single and INCR-burst read/write transactions from the bus onto a single-port word SRAM macro. It is the far end of the CPU wrapper's master ports: it accepts AR/AW/W from the interconnect and returns R/B. One transaction is in flight at a time. It replaces the non-burst slave logic for IM/DM, so the L1 caches' 4-beat line fills are served natively.

Parameters:
ID_W, 8, slave-side AXI ID width (4-bit master ID + 4-bit master index)
ADDR_W, 32, AXI address width
DATA_W, 32, data width; one word per beat
LEN_W, 4, AxLEN width; burst length is AxLEN+1
SRAM_AW, 14, SRAM word-address width; SRAM index = ADDR[SRAM_AW+1:2]

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/LEN_W/3/2  read address
ARVALID in 1; ARREADY out 1  read address handshake
RID out ID_W; RDATA out DATA_W; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1  read data
AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/LEN_W/3/2  write address
AWVALID in 1; AWREADY out 1  write address handshake
WDATA in DATA_W; WSTRB in 4; WLAST in 1; WVALID in 1; WREADY out 1  write data
BID out ID_W; BRESP out 2; BVALID out 1; BREADY in 1  write response
sram_ceb  out  1  chip enable, active-low
sram_web  out  4  per-byte write enable, active-low (F = read)
sram_a  out  SRAM_AW  word address
sram_di  out  DATA_W  write data
sram_do  in  DATA_W  read data, valid one cycle after address applied with ceb=0, web=F

Behaviour:
- Reset (async, rst=1): state IDLE; every VALID/READY and RLAST = 0; RDATA, RID, BID = 0; RRESP/BRESP = 0; sram_ceb=1, sram_web=F. ARREADY/AWREADY are gated by ~rst.
- States: IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP.
- IDLE: AWREADY=1; ARREADY = ~AWVALID. Write wins a simultaneous AW/AR; the AR is held by the master and accepted after the write completes. On handshake, latch ID, SRAM index (ADDR[SRAM_AW+1:2]), LEN, and BURST; clear beat counter.
- AR accepted -> RD_FETCH: drive sram_a=index, ceb=0, web=F for one cycle -> RD_DATA.
- RD_DATA: RVALID=1, RID=latched ID, RLAST=(beat==LEN), RRESP=OKAY (2'b00).
  - RDATA = sram_do in the first cycle of the beat, then a hold register while RREADY=0. Data is stable until handshake.
  - Prefetch: while in RD_DATA and not last, sram_a = index+1 with ceb=0 whenever RVALID&RREADY. The next beat is presented the next cycle.
  - Throughput: first beat 2 cycles after AR handshake, then 1 beat/cycle with RREADY held high.
  - On RVALID&RREADY&RLAST -> IDLE (ARREADY may assert that next cycle).
- AW accepted -> WR_DATA: WREADY=1. On each WVALID&WREADY, same cycle: sram_a=index, ceb=0, web=~WSTRB, sram_di=WDATA. Then index+1, beat+1. WSTRB=0 issues no write (web=F).
- WR_DATA exit: on the WLAST handshake -> WR_RESP. BRESP=OKAY if beat==LEN, else SLVERR (2'b10). If beat reaches LEN without WLAST, further beats are ignored (WREADY stays 1, no SRAM write) until WLAST; then BRESP=SLVERR.
- WR_RESP: BVALID=1, BID=latched ID; hold until BREADY -> IDLE.
- Burst type: ARBURST/AWBURST != INCR (2'b01) -> beat count is still honoured, but there is no SRAM access. Read beats return RDATA=0, RRESP=SLVERR. Writes end with BRESP=SLVERR.
- Address/size rules: the index wraps modulo 2^SRAM_AW within a burst; ADDR[1:0] and upper bits are ignored. AxSIZE is assumed word and is not checked.
- Outside active accesses: sram_ceb=1, sram_web=F.
- Reset asserted mid-burst: immediate return to IDLE, outputs to reset values; no response is issued for the aborted transaction.

Test Plan:
- AR id=8'h10, addr=0x0000_0040, len=3, RREADY=1; SRAM[16..19]=A,B,C,D -> R beats A,B,C,D on consecutive cycles, first 2 cycles after handshake; RLAST on D only; RID=8'h10; RRESP=0.
- Same burst with RREADY low for 3 cycles on beat 2 -> RDATA holds B, RVALID stays 1, sram_a does not advance; sequence is unchanged.
- AW id=8'h21, addr=0x0000_0100, len=0; W data 0xDEADBEEF, strb 4'b0011, WLAST -> sram_web=4'b1100 at index 0x40 that cycle; BVALID next cycle with BID=8'h21, BRESP=0; BREADY delayed 2 cycles, BVALID held.
- AWVALID and ARVALID asserted together in IDLE -> AWREADY=1, ARREADY=0; the write completes, then the AR is accepted on the cycle after the B handshake.
- AW len=3 but WLAST on beat 1 -> 2 SRAM writes, BRESP=2'b10; AR with ARBURST=2'b00, len=1 -> 2 beats RDATA=0, RRESP=2'b10, ceb stays 1.
- Index 0x3FFF with len=1 read -> second beat reads index 0x0000. rst pulse during the write data phase -> all outputs 0, ceb=1, state IDLE; the next AW is accepted normally.
